// File: rtl/spi_reg_bank.sv
// SPI frame command FIFO and peripheral control register bank with error accounting.
// Optional read-back path enabled by defining SPI_READBACK_EN.
module spi_reg_bank #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read_write,
  input  logic [6:0]           addr,
  input  logic [7:0]           data,
  input  logic                 valid,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef SPI_READBACK_EN
  ,
  output logic [7:0]           rd_data,
  output logic                 rd_valid
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // State table:
  //   IDLE   | wait for a queued command, pop it into cmd_q
  //   DECODE | classify the popped command
  //   COMMIT | write data into the addressed register
  //   REJECT | bump the saturating error counter
  //   READ   | (read-back builds only) present the addressed register
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    COMMIT = 3'd2,
    REJECT = 3'd3,
    READ   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 valid_q;
  logic                 overflow_q;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [15:0]          mem_q [FIFO_DEPTH];
  logic [15:0]          cmd_q;
  logic [7:0]           regs_q [5];
  logic [7:0]           regs_d [5];

  logic       capture, full, push, pop;
  logic       cmd_rw, addr_ok;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;

  assign capture  = valid & ~valid_q;
  assign full     = (cnt_q == FULL_CNT);
  assign push     = capture & ~full;
  assign cmd_rw   = cmd_q[15];
  assign cmd_addr = cmd_q[14:8];
  assign cmd_data = cmd_q[7:0];
  assign addr_ok  = (cmd_addr <= 7'd4);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    err_d   = err_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (addr_ok && cmd_rw) state_d = COMMIT;
`ifdef SPI_READBACK_EN
        else if (addr_ok)      state_d = READ;
`endif
        else                   state_d = REJECT;
      end
      COMMIT: begin
        for (int i = 0; i < 5; i++) begin
          if (cmd_addr == 7'(i)) regs_d[i] = cmd_data;
        end
        state_d = IDLE;
      end
      REJECT: begin
        if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fullness is judged on the pre-pop count, so a same-cycle pop never makes room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b1;
      overflow_q <= 1'b0;
      err_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid;
      err_q   <= err_d;
      regs_q  <= regs_d;
      if (capture && full) overflow_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cmd_q    <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {read_write, addr, data};
  end

`ifdef SPI_READBACK_EN
  logic [7:0] rd_sel;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_addr == 7'(i)) rd_sel = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == READ);
      if (state_q == READ) rd_data_q <= rd_sel;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign overflow        = overflow_q;
  assign err_count       = err_q;

endmodule
